mdio_mgmt_ctrl: RTL

Clause-22 MDIO management master that shares one PHY management bus between two requesters. Typical requesters are a PHY bring-up sequencer and the system CPU bridge. Runs in the `sys_clk` domain and drives one Ethernet port's `ENET_MDC` and `ENET_MDIO` pins through the top-level tristate, where `oen` high means the pin is released. The block arbitrates round-robin, serialises one 64-bit read or write frame per grant, captures read data, and returns a one-cycle response to the granted requester.

---
 rtl/mdio_mgmt_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mdio_mgmt_ctrl.sv
// mdio_mgmt_ctrl
// ---------------------------------------------------------------------------
// Clause-22 MDIO management master shared by two requesters (for example a
// PHY bring-up sequencer and a CPU bridge). The two requesters are arbitrated
// round-robin. Each grant sends one 64-bit read or write frame on MDC/MDIO.
// Read data is shifted in from the PHY. A one-cycle response pulse is then
// returned to the requester that owned the frame.
//
// Parameters
//   ClkDiv        clk cycles per MDC half-period (>= 2); f_mdc = f_clk/(2*ClkDiv)
//
// Ports
//   clk           system clock (only clock)
//   rst           synchronous active-high reset
//   req_valid[1:0]    per-requester request valid
//   req_ready[1:0]    per-requester accept (combinational, at most one high)
//   req_write[1:0]    per-requester opcode, 1 = write, 0 = read
//   req_phy_addr[9:0] {phy1, phy0}
//   req_reg_addr[9:0] {reg1, reg0}
//   req_wdata[31:0]   {wd1, wd0}
//   rsp_valid[1:0]    one-cycle completion pulse to the frame owner
//   rsp_rdata[15:0]   read data (0x0000 after a write), held until next completion
//   busy          high whenever the controller is not idle
//   mdc           management clock
//   mdio_in       MDIO pin input
//   mdio_out      MDIO drive value
//   mdio_oen      1 = release the pin, 0 = drive it
// ---------------------------------------------------------------------------
module mdio_mgmt_ctrl #(
    parameter int ClkDiv = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [9:0]  req_phy_addr,
    input  logic [9:0]  req_reg_addr,
    input  logic [31:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen
);

    // The divider counts a whole bit period (0 .. 2*ClkDiv-1). MDC is low for
    // the first half of the count and high for the second half.
    localparam int DIV_W = $clog2(ClkDiv) + 1;
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(ClkDiv - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * ClkDiv - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;       // requester granted most recently
    logic               owner_q, owner_d;     // requester owning the current frame
    logic               write_q, write_d;
    logic [63:0]        frame_q, frame_d;     // bit 63 is the bit on the wire
    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic [15:0]        rdsh_q, rdsh_d;       // read data shift register
    logic [15:0]        rsp_rdata_q, rsp_rdata_d;
    logic               mdc_q, mdc_d;
    logic               oen_q, oen_d;

    // ---------------------------------------------------------------------
    // Arbitration: a single valid requester wins. On a tie the winner is
    // the requester that was not served last.
    // ---------------------------------------------------------------------
    logic        grant;
    logic        accept;
    logic        sel_write;
    logic [4:0]  sel_phy;
    logic [4:0]  sel_reg;
    logic [15:0] sel_wdata;
    logic [63:0] new_frame;

    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = 1'b0;
        endcase
    end

    assign accept = (state_q == ST_IDLE) & ~rst & (|req_valid);

    assign sel_write = grant ? req_write[1]         : req_write[0];
    assign sel_phy   = grant ? req_phy_addr[9:5]    : req_phy_addr[4:0];
    assign sel_reg   = grant ? req_reg_addr[9:5]    : req_reg_addr[4:0];
    assign sel_wdata = grant ? req_wdata[31:16]     : req_wdata[15:0];

    // Preamble, ST=01, OP, PHYAD, REGAD, then TA+DATA. For reads the TA and
    // DATA positions are released, so ones are loaded there to keep the
    // drive value at the bus-idle level.
    assign new_frame = {32'hFFFF_FFFF, 2'b01,
                        (sel_write ? 2'b01 : 2'b10),
                        sel_phy, sel_reg,
                        (sel_write ? {2'b10, sel_wdata} : 18'h3FFFF)};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_ready[gi] = accept & (grant == 1'(gi));
            assign rsp_valid[gi] = (state_q == ST_DONE) & (owner_q == 1'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Next-state logic. MDC and OEN are registered. They are computed from
    // the counter values they will sit beside, so the pins change cleanly on
    // clock edges. MDIO/OEN change only at bit boundaries (MDC falling).
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        write_d     = write_q;
        frame_d     = frame_q;
        div_d       = div_q;
        bit_d       = bit_q;
        rdsh_d      = rdsh_q;
        rsp_rdata_d = rsp_rdata_q;
        mdc_d       = 1'b0;
        oen_d       = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    last_d  = grant;
                    owner_d = grant;
                    write_d = sel_write;
                    frame_d = new_frame;
                    div_d   = '0;
                    bit_d   = 6'd0;
                    rdsh_d  = 16'h0000;
                    oen_d   = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == 6'd63) begin
                        // Last bit done: go to DONE rather than wrapping the counter.
                        state_d     = ST_DONE;
                        frame_d     = '1;
                        rsp_rdata_d = write_q ? 16'h0000 : rdsh_q;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                        frame_d = {frame_q[62:0], 1'b1};
                        // Reads turn the bus around from bit 46 (TA) on.
                        oen_d   = ~write_q & (bit_q >= 6'd45);
                    end
                end else begin
                    div_d = div_q + 1'b1;
                    mdc_d = (div_q >= DIV_HALF);
                    oen_d = oen_q;
                    // This edge raises MDC, so it is the sample point.
                    if ((div_q == DIV_HALF) && !write_q && (bit_q >= 6'd48)) begin
                        rdsh_d = {rdsh_q[14:0], mdio_in};
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            write_q     <= 1'b0;
            frame_q     <= '1;
            div_q       <= '0;
            bit_q       <= 6'd0;
            rdsh_q      <= 16'h0000;
            rsp_rdata_q <= 16'h0000;
            mdc_q       <= 1'b0;
            oen_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            write_q     <= write_d;
            frame_q     <= frame_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            rdsh_q      <= rdsh_d;
            rsp_rdata_q <= rsp_rdata_d;
            mdc_q       <= mdc_d;
            oen_q       <= oen_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mdc       = mdc_q;
    assign mdio_oen  = oen_q;
    assign mdio_out  = frame_q[63];
    assign rsp_rdata = rsp_rdata_q;

endmodule
